// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, oversampling constants and vote helper for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    // Sample numbers (1-based) within a bit that take part in the vote.
    localparam logic [3:0] SAMPLE_A = 4'd7;
    localparam logic [3:0] SAMPLE_B = 4'd8;
    localparam logic [3:0] SAMPLE_C = 4'd9;

    // Sample-counter value on the tick that closes a bit period.
    localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, held at phase zero while cleared
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_clear  forces the divider count to 0 (receiver idle)
//   o_tick   one-cycle pulse every TICK_DIV cycles while not cleared
module uart_baud_tick #(
    parameter int TICK_DIV = 651
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_clear || r_cnt == LAST) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_tick = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive front end with 16x oversampling and sticky status
//
// Ports:
//   sysclk        system clock, rising edge
//   reset         asynchronous active-low reset
//   uart_rx       raw serial line, idle high, asynchronous
//   rx_ack        one-cycle pulse: data register has been read
//   rx_data       last accepted byte
//   rx_valid      rx_data holds an unread byte
//   rx_frame_err  sticky: a frame was dropped for a low stop bit
//   rx_overrun    sticky: a good frame was dropped because rx_valid was set
//   rx_busy       a frame is in progress
module uart_receiver
    import uart_pkg::*;
#(
    parameter int TICK_DIV  = 651,
    parameter int DATA_BITS = 8
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 uart_rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    rx_state_t            r_state;
    rx_state_t            w_next_state;
    logic [3:0]           r_samp_cnt;
    logic [2:0]           r_bit_cnt;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic [DATA_BITS-1:0] r_shift;

    logic w_rx_s;
    logic w_tick;
    logic w_at_a;
    logic w_at_b;
    logic w_decide;
    logic w_boundary;
    logic w_bit;
    logic w_shift_en;
    logic w_commit;
    logic w_ferr_set;

    assign w_rx_s = r_sync2;

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_baud_tick (
        .i_clk   (sysclk),
        .i_rst_n (reset),
        .i_clear (r_state == S_IDLE),
        .o_tick  (w_tick)
    );

    // The tick that completes sample k sees the counter still at k-1.
    assign w_at_a     = w_tick && (r_samp_cnt == SAMPLE_A - 4'd1);
    assign w_at_b     = w_tick && (r_samp_cnt == SAMPLE_B - 4'd1);
    assign w_decide   = w_tick && (r_samp_cnt == SAMPLE_C - 4'd1);
    assign w_boundary = w_tick && (r_samp_cnt == SAMPLE_LAST);

    // Third vote is the live sample, so the decision is ready on the deciding tick itself.
    assign w_bit = majority3(r_samp_a, r_samp_b, w_rx_s);

    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_commit     = 1'b0;
        w_ferr_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_decide && w_bit) begin
                    w_next_state = S_IDLE;
                end else if (w_boundary) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                w_shift_en = w_decide;
                if (w_boundary && r_bit_cnt == LAST_BIT) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a following start edge is not missed.
                if (w_decide) begin
                    if (w_bit) begin
                        w_commit     = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_ferr_set   = 1'b1;
                        w_next_state = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= S_IDLE;
            r_samp_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_samp_a   <= 1'b1;
            r_samp_b   <= 1'b1;
            r_shift    <= '0;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_state <= w_next_state;

            if (r_state == S_IDLE) begin
                r_samp_cnt <= 4'd0;
            end else if (w_tick) begin
                r_samp_cnt <= r_samp_cnt + 4'd1;
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= 3'd0;
            end else if (w_boundary) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_at_a) begin
                r_samp_a <= w_rx_s;
            end
            if (w_at_b) begin
                r_samp_b <= w_rx_s;
            end

            if (w_shift_en) begin
                r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // Data register and sticky flags: a set always beats an ack clear.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            if (w_commit && (!rx_valid || rx_ack)) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (w_commit && rx_valid && !rx_ack) begin
                rx_overrun <= 1'b1;
            end else if (rx_ack) begin
                rx_overrun <= 1'b0;
            end

            if (w_ferr_set) begin
                rx_frame_err <= 1'b1;
            end else if (rx_ack) begin
                rx_frame_err <= 1'b0;
            end
        end
    end

    assign rx_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int TICK_DIV = 4;
    localparam int BIT      = 16 * TICK_DIV;
    localparam int LAT_MIN  = 612;
    localparam int LAT_MAX  = 616;

    logic       sysclk  = 1'b0;
    logic       reset   = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_ack  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    uart_receiver #(
        .TICK_DIV  (TICK_DIV),
        .DATA_BITS (8)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    typedef struct {
        logic [7:0] byte_in;
        logic       stop_v;
        logic       exp_valid;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge sysclk);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge sysclk);
        rx_ack = 1'b0;
    endtask

    // Drives start, 8 data bits LSB first, then the stop level for stop_cycles.
    // lat is the cycle count from the falling edge to the first rx_valid rise (-1 if none).
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_cycles,
                              input logic ack_first, input int abort_at, output int lat);
        logic [9:0] bits;
        logic       prev;
        int         n;
        bits = {stop_v, b, 1'b0};
        n    = 9 * BIT + stop_cycles;
        if (abort_at > 0 && abort_at < n) n = abort_at;
        lat  = -1;
        prev = rx_valid;
        for (int c = 0; c < n; c++) begin
            uart_rx = (c < 9 * BIT) ? bits[c / BIT] : stop_v;
            rx_ack  = ack_first && (c == 0);
            @(negedge sysclk);
            if (rx_valid && !prev && lat < 0) lat = c + 1;
            prev = rx_valid;
        end
        rx_ack = 1'b0;
    endtask

    initial begin
        int lat;

        vecs[0] = '{8'h0C, 1'b1, 1'b1, 1'b0, 8'h0C};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};

        repeat (3) @(negedge sysclk);
        check("rst_data",  rx_data,      32'h00);
        check("rst_valid", rx_valid,     32'h0);
        check("rst_ferr",  rx_frame_err, 32'h0);
        check("rst_ovr",   rx_overrun,   32'h0);
        check("rst_busy",  rx_busy,      32'h0);
        reset = 1'b1;
        idle(10);

        // Single frames from a clean state
        for (int i = 0; i < 7; i++) begin
            idle(10);
            pulse_ack();
            send_frame(vecs[i].byte_in, vecs[i].stop_v, BIT, 1'b0, 0, lat);
            if (vecs[i].exp_valid) check_range($sformatf("vec%0d_lat", i), lat, LAT_MIN, LAT_MAX);
            else                   check($sformatf("vec%0d_norise", i), lat, 32'hFFFF_FFFF);
            check($sformatf("vec%0d_data", i),  rx_data,      vecs[i].exp_data);
            check($sformatf("vec%0d_valid", i), rx_valid,     vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i),  rx_frame_err, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i),   rx_overrun,   32'h0);
        end

        // Back-to-back frames with an ack between them
        idle(10);
        pulse_ack();
        send_frame(8'h0C, 1'b1, BIT, 1'b0, 0, lat);
        check("b2b_first_data", rx_data, 32'h0C);
        send_frame(8'h09, 1'b1, BIT, 1'b1, 0, lat);
        check_range("b2b_lat", lat, LAT_MIN, LAT_MAX);
        check("b2b_data",  rx_data,      32'h09);
        check("b2b_valid", rx_valid,     32'h1);
        check("b2b_ferr",  rx_frame_err, 32'h0);
        check("b2b_ovr",   rx_overrun,   32'h0);

        // Overrun: second frame dropped, first byte kept
        idle(10);
        pulse_ack();
        send_frame(8'h0C, 1'b1, BIT, 1'b0, 0, lat);
        send_frame(8'h09, 1'b1, BIT, 1'b0, 0, lat);
        check("ovr_data",  rx_data,    32'h0C);
        check("ovr_valid", rx_valid,   32'h1);
        check("ovr_flag",  rx_overrun, 32'h1);
        pulse_ack();
        check("ovr_ack_valid", rx_valid,   32'h0);
        check("ovr_ack_flag",  rx_overrun, 32'h0);

        // Frame error with the line held low for three bit times
        idle(10);
        send_frame(8'h55, 1'b0, 3 * BIT, 1'b0, 0, lat);
        check("ferr_flag",  rx_frame_err, 32'h1);
        check("ferr_valid", rx_valid,     32'h0);
        check("ferr_busy",  rx_busy,      32'h1);
        idle(5);
        check("ferr_release_busy", rx_busy,      32'h0);
        check("ferr_sticky",       rx_frame_err, 32'h1);
        pulse_ack();
        check("ferr_ack", rx_frame_err, 32'h0);

        // Start-bit glitch rejection, then a real frame
        idle(10);
        uart_rx = 1'b0;
        repeat (20) @(negedge sysclk);
        uart_rx = 1'b1;
        repeat (3) @(negedge sysclk);
        check("glitch_busy", rx_busy, 32'h1);
        repeat (60) @(negedge sysclk);
        check("glitch_idle",  rx_busy,      32'h0);
        check("glitch_valid", rx_valid,     32'h0);
        check("glitch_ferr",  rx_frame_err, 32'h0);
        check("glitch_ovr",   rx_overrun,   32'h0);
        send_frame(8'hA5, 1'b1, BIT, 1'b0, 0, lat);
        check("after_glitch_data",  rx_data,  32'hA5);
        check("after_glitch_valid", rx_valid, 32'h1);

        // Reset in the middle of the data bits
        idle(10);
        send_frame(8'h3C, 1'b1, BIT, 1'b0, 4 * BIT + 10, lat);
        check("mid_busy", rx_busy, 32'h1);
        reset = 1'b0;
        #1;
        check("midrst_data",  rx_data,      32'h00);
        check("midrst_valid", rx_valid,     32'h0);
        check("midrst_busy",  rx_busy,      32'h0);
        check("midrst_ferr",  rx_frame_err, 32'h0);
        check("midrst_ovr",   rx_overrun,   32'h0);
        uart_rx = 1'b1;
        @(negedge sysclk);
        reset = 1'b1;
        idle(10);
        send_frame(8'h3C, 1'b1, BIT, 1'b0, 0, lat);
        check_range("postrst_lat", lat, LAT_MIN, LAT_MAX);
        check("postrst_data",  rx_data,  32'h3C);
        check("postrst_valid", rx_valid, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive front end that sits directly upstream of the Pipeline CPU's peripheral bus, converting the board's UART_RX line into bytes.
- Frame format: 8N1, LSB first, with 16x oversampling and 3-sample majority voting.
- Holds each byte in a one-entry data register with sticky status flags until the CPU's data-register read (rx_ack) consumes it.

Parameters:
TICK_DIV, 651, sysclk cycles per oversample tick (100 MHz / (9600 x 16)); legal range 2..65535
DATA_BITS, 8, payload bits per frame; fixed at 8 for this design

Ports:
sysclk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
uart_rx  in  1  raw serial line, idle high, asynchronous to sysclk
rx_ack  in  1  one-cycle pulse: CPU has read the data register
rx_data  out  8  last accepted byte
rx_valid  out  1  rx_data holds an unread byte
rx_frame_err  out  1  sticky: frame discarded because its stop bit sampled low
rx_overrun  out  1  sticky: a good frame was dropped because rx_valid was already set
rx_busy  out  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset (reset=0, async):
  - Synchronizer flops to 1; tick and sample counters to 0; state to IDLE.
  - rx_data=0x00; rx_valid, rx_frame_err, rx_overrun, rx_busy all 0.
  - Reset mid-frame abandons the frame; nothing is committed.
- Synchronizer: two flops on uart_rx. All decisions use the synchronized bit rx_s.
- Tick generator:
  - Counter runs 0..TICK_DIV-1; tick pulses for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
  - The counter is forced to 0 while in IDLE, so ticks are phase-aligned to the start edge.
- Sample counter: 0..15; advances on each tick and wraps at 15, which marks the bit boundary.
- Bit decision: majority of rx_s taken at sample counts 7, 8 and 9. The decision is made on the tick that completes sample 9.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START.
  - START: majority 1 -> IDLE (glitch rejected, no flag set). Majority 0 -> DATA at the bit boundary.
  - DATA: each decided bit is shifted into bit 7 of the shift register (shift right). After the 8th bit -> STOP at the bit boundary.
  - STOP: at the sample-9 decision, majority 1 -> commit and go to IDLE. Majority 0 -> set rx_frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s==1 (break/line-low guard), then -> IDLE.
- Committing at stop sample 9 (not at the end of the stop bit) lets the receiver catch back-to-back frames.
- Commit, in the cycle after the deciding tick:
  - If rx_valid==0, or rx_ack is high in the same cycle: rx_data <= shift register, rx_valid <= 1.
  - Otherwise: rx_overrun <= 1; rx_data and rx_valid are unchanged (the new byte is dropped).
- rx_ack:
  - Clears rx_valid, rx_frame_err and rx_overrun on the next edge.
  - Ack with rx_valid==0 still clears the flags.
  - Ack coincident with a commit: the commit wins for rx_valid (it stays 1); the flags are still cleared unless the commit itself sets overrun, which cannot happen in that case.
- Frame error coincident with ack: rx_frame_err is set, because the set has priority over the clear.
- Latency: from the uart_rx falling edge to rx_valid rising is 153 ticks x TICK_DIV + 3..4 cycles (2 sync + 1 commit + start-phase jitter).
- Counter widths: tick counter is 16 bits; sample counter 4 bits; bit counter 3 bits.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4 (3 bits).
  - OVERSAMPLE=16.
  - SAMPLE_A/B/C=7/8/9.
- Sub-module uart_baud_tick: tick counter with parameter TICK_DIV, a clear input, and a one-cycle tick output.
- The FSM, shift register, data register and flags live in uart_receiver.

Test Plan:
- TICK_DIV=4 (bit = 64 clocks). Send frame 0x0C (line: 0, then bits 0,0,1,1,0,0,0,0, then 1) -> rx_data=0x0C, rx_valid=1 within 612..616 clocks of the falling edge; rx_frame_err=0, rx_overrun=0.
- Send 0x09 back-to-back with no idle gap after 0x0C, pulsing rx_ack between frames -> second commit gives rx_data=0x09, rx_valid=1, no flags.
- Send 0x0C then 0x09 with no rx_ack -> rx_data stays 0x0C, rx_valid=1, rx_overrun=1. A subsequent rx_ack gives rx_valid=0, rx_overrun=0.
- Frame 0x55 with the stop bit driven 0 and the line held low for 3 bit times -> rx_frame_err=1, rx_valid=0, rx_busy=1 until the line returns high, then rx_busy=0.
- 20-clock low glitch on an idle line -> returns to IDLE after the start check, rx_valid=0, no flags. The next real frame 0xA5 is received correctly.
- Assert reset=0 mid-DATA of frame 0x3C -> all outputs 0 immediately. Release reset with the line idle, then send 0x3C -> rx_data=0x3C, rx_valid=1.
